// File: rtl/alu_sequencer.sv
// Issue-side controller for the 32-bit ALU: decodes one instruction at a time,
// waits out the ALU's registered latency and returns the result with status flags.
module alu_sequencer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [5:0]       in_opcode,
  input  logic [5:0]       in_funct,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_b,
  output logic [1:0]       alu_ctrl,
  output logic [31:0]      alu_a,
  output logic [31:0]      alu_b,
  input  logic [31:0]      alu_r,
  input  logic             alu_ovf,
  input  logic             alu_branch,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_r,
  output logic             out_zero,
  output logic             out_ovf,
  output logic             out_taken,
  output logic             out_illegal,
  output logic [CNT_W-1:0] ovf_cnt,
  output logic [CNT_W-1:0] br_cnt,
  output logic [1:0]       state_dbg
);

  localparam logic [1:0] CTRL_ADD = 2'b00;
  localparam logic [1:0] CTRL_SUB = 2'b01;
  localparam logic [1:0] CTRL_XOR = 2'b10;
  localparam logic [1:0] CTRL_BEQ = 2'b11;

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, DONE} state_t;
  state_t state;

  logic [1:0]  dec_ctrl;
  logic        dec_illegal;
  logic [31:0] cap_r;
  logic        cap_ovf;
  logic        cap_taken;

  // Valid/ready: a transfer happens on a rising edge where both valid and ready
  // are high; the producer holds its payload stable until that edge.
  assign in_ready  = (state == IDLE);
  assign state_dbg = state;

  always_comb begin
    dec_ctrl    = CTRL_ADD;
    dec_illegal = 1'b1;
    if (in_opcode == 6'h00) begin
      case (in_funct)
        6'h20:   begin dec_ctrl = CTRL_ADD; dec_illegal = 1'b0; end
        6'h22:   begin dec_ctrl = CTRL_SUB; dec_illegal = 1'b0; end
        6'h26:   begin dec_ctrl = CTRL_XOR; dec_illegal = 1'b0; end
        default: begin dec_ctrl = CTRL_ADD; dec_illegal = 1'b1; end
      endcase
    end else if (in_opcode == 6'h04) begin
      dec_ctrl    = CTRL_BEQ;
      dec_illegal = 1'b0;
    end
  end

  // The ALU leaves R untouched on a taken compare, so BEQ reports zero.
  always_comb begin
    cap_r     = alu_r;
    cap_ovf   = 1'b0;
    cap_taken = 1'b0;
    case (alu_ctrl)
      CTRL_ADD, CTRL_SUB: cap_ovf = alu_ovf;
      CTRL_BEQ: begin
        cap_r     = '0;
        cap_taken = alu_branch;
      end
      default: cap_r = alu_r;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      alu_ctrl    <= CTRL_ADD;
      alu_a       <= '0;
      alu_b       <= '0;
      out_valid   <= 1'b0;
      out_r       <= '0;
      out_zero    <= 1'b0;
      out_ovf     <= 1'b0;
      out_taken   <= 1'b0;
      out_illegal <= 1'b0;
      ovf_cnt     <= '0;
      br_cnt      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (dec_illegal) begin
              // Illegal ops never reach the ALU, so its operands keep the last legal op.
              out_r       <= '0;
              out_zero    <= 1'b1;
              out_ovf     <= 1'b0;
              out_taken   <= 1'b0;
              out_illegal <= 1'b1;
              out_valid   <= 1'b1;
              state       <= DONE;
            end else begin
              alu_ctrl <= dec_ctrl;
              alu_a    <= in_a;
              alu_b    <= in_b;
              state    <= ISSUE;
            end
          end
        end
        ISSUE: state <= CAPTURE;
        CAPTURE: begin
          out_r       <= cap_r;
          out_zero    <= (cap_r == 32'h0);
          out_ovf     <= cap_ovf;
          out_taken   <= cap_taken;
          out_illegal <= 1'b0;
          out_valid   <= 1'b1;
          if (cap_ovf && (ovf_cnt != '1)) ovf_cnt <= ovf_cnt + 1'b1;
          if (cap_taken && (br_cnt != '1)) br_cnt <= br_cnt + 1'b1;
          state <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: behavioural registered ALU, reference model feeding an
// expected-result queue, one task per scenario.
module tb_alu_sequencer;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [5:0]       in_opcode;
  logic [5:0]       in_funct;
  logic [31:0]      in_a;
  logic [31:0]      in_b;
  logic [1:0]       alu_ctrl;
  logic [31:0]      alu_a;
  logic [31:0]      alu_b;
  logic [31:0]      alu_r;
  logic             alu_ovf;
  logic             alu_branch;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_r;
  logic             out_zero;
  logic             out_ovf;
  logic             out_taken;
  logic             out_illegal;
  logic [CNT_W-1:0] ovf_cnt;
  logic [CNT_W-1:0] br_cnt;
  logic [1:0]       state_dbg;

  int checks = 0;
  int errors = 0;

  // Packed as {illegal, taken, ovf, zero, r}
  logic [35:0]      exp_q[$];
  logic [CNT_W-1:0] exp_ovf_cnt;
  logic [CNT_W-1:0] exp_br_cnt;
  logic [1:0]       last_ctrl;
  logic [31:0]      last_a;
  logic [31:0]      last_b;

  always #5 clk = ~clk;

  alu_sequencer #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_funct(in_funct), .in_a(in_a), .in_b(in_b),
    .alu_ctrl(alu_ctrl), .alu_a(alu_a), .alu_b(alu_b), .alu_r(alu_r),
    .alu_ovf(alu_ovf), .alu_branch(alu_branch), .out_valid(out_valid),
    .out_ready(out_ready), .out_r(out_r), .out_zero(out_zero), .out_ovf(out_ovf),
    .out_taken(out_taken), .out_illegal(out_illegal), .ovf_cnt(ovf_cnt),
    .br_cnt(br_cnt), .state_dbg(state_dbg)
  );

  // Registered ALU; a not-taken compare scribbles R so a sequencer that forwards it shows up.
  always_ff @(posedge clk) begin
    case (alu_ctrl)
      2'b00: begin {alu_ovf, alu_r} <= {1'b0, alu_a} + {1'b0, alu_b}; alu_branch <= 1'b0; end
      2'b01: begin {alu_ovf, alu_r} <= {1'b0, alu_a} - {1'b0, alu_b}; alu_branch <= 1'b0; end
      2'b10: begin alu_r <= alu_a ^ alu_b; alu_ovf <= 1'b0; alu_branch <= 1'b0; end
      default: begin
        alu_branch <= (alu_a == alu_b);
        if (alu_a != alu_b) alu_r <= 32'hDEAD_BEEF;
      end
    endcase
  end

  function automatic logic [35:0] model(input logic [5:0] op, input logic [5:0] fn,
                                        input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    logic [31:0] r;
    logic ovf, taken, ill;
    s = '0; r = '0; ovf = 1'b0; taken = 1'b0; ill = 1'b0;
    if (op == 6'h00 && fn == 6'h20) begin
      s = {1'b0, a} + {1'b0, b}; r = s[31:0]; ovf = s[32];
    end else if (op == 6'h00 && fn == 6'h22) begin
      s = {1'b0, a} - {1'b0, b}; r = s[31:0]; ovf = s[32];
    end else if (op == 6'h00 && fn == 6'h26) begin
      r = a ^ b;
    end else if (op == 6'h04) begin
      taken = (a == b);
    end else begin
      ill = 1'b1;
    end
    return {ill, taken, ovf, (r == 32'h0), r};
  endfunction

  // Called at a falling edge with the DUT idle; returns at the falling edge after acceptance.
  task automatic issue(input logic [5:0] op, input logic [5:0] fn,
                       input logic [31:0] a, input logic [31:0] b);
    logic [35:0] e;
    e = model(op, fn, a, b);
    exp_q.push_back(e);
    if (!e[35]) begin
      last_a = a;
      last_b = b;
      if (op == 6'h04) last_ctrl = 2'b11;
      else if (fn == 6'h20) last_ctrl = 2'b00;
      else if (fn == 6'h22) last_ctrl = 2'b01;
      else last_ctrl = 2'b10;
    end
    in_opcode = op; in_funct = fn; in_a = a; in_b = b; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic collect(input int exp_cyc);
    int cyc;
    logic [35:0] e, got;
    cyc = 1;
    while (out_valid !== 1'b1 && cyc < 12) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (cyc != exp_cyc) begin
      errors++;
      $display("FAIL latency: got %0d cycles expected %0d", cyc, exp_cyc);
    end
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard: expected queue empty");
      return;
    end
    e = exp_q.pop_front();
    got = {out_illegal, out_taken, out_ovf, out_zero, out_r};
    checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL result: got ill/tk/ovf/z/r=%h expected %h", got, e);
    end
    if (e[33] && exp_ovf_cnt != '1) exp_ovf_cnt = exp_ovf_cnt + 1'b1;
    if (e[34] && exp_br_cnt != '1) exp_br_cnt = exp_br_cnt + 1'b1;
    checks++;
    if (ovf_cnt !== exp_ovf_cnt || br_cnt !== exp_br_cnt) begin
      errors++;
      $display("FAIL counters: got ovf=%0d br=%0d expected ovf=%0d br=%0d",
               ovf_cnt, br_cnt, exp_ovf_cnt, exp_br_cnt);
    end
    checks++;
    if ({alu_ctrl, alu_a, alu_b} !== {last_ctrl, last_a, last_b}) begin
      errors++;
      $display("FAIL alu_inputs: got %b %h %h expected %b %h %h",
               alu_ctrl, alu_a, alu_b, last_ctrl, last_a, last_b);
    end
  endtask

  task automatic retire();
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL retire: got out_valid=%b in_ready=%b expected 0 1", out_valid, in_ready);
    end
  endtask

  task automatic run_op(input logic [5:0] op, input logic [5:0] fn,
                        input logic [31:0] a, input logic [31:0] b);
    logic [35:0] e;
    e = model(op, fn, a, b);
    issue(op, fn, a, b);
    collect(e[35] ? 1 : 3);
    retire();
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in_opcode = '0; in_funct = '0; in_a = '0; in_b = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({out_valid, out_r, out_zero, out_ovf, out_taken, out_illegal} !== 37'h0) begin
      errors++;
      $display("FAIL reset_out: got v=%b r=%h z=%b o=%b t=%b i=%b expected all 0",
               out_valid, out_r, out_zero, out_ovf, out_taken, out_illegal);
    end
    checks++;
    if ({alu_ctrl, alu_a, alu_b} !== 66'h0 || ovf_cnt !== '0 || br_cnt !== '0) begin
      errors++;
      $display("FAIL reset_alu_cnt: got %b %h %h %0d %0d expected zeros",
               alu_ctrl, alu_a, alu_b, ovf_cnt, br_cnt);
    end
    reset = 1'b0;
    exp_ovf_cnt = '0; exp_br_cnt = '0;
    last_ctrl = 2'b00; last_a = '0; last_b = '0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || state_dbg !== 2'd0) begin
      errors++;
      $display("FAIL reset_idle: got in_ready=%b state=%0d expected 1 0", in_ready, state_dbg);
    end
  endtask

  task automatic test_add();
    run_op(6'h00, 6'h20, 32'h5, 32'h3);
  endtask

  task automatic test_overflow();
    run_op(6'h00, 6'h20, 32'hFFFF_FFFF, 32'h1);
    run_op(6'h00, 6'h22, 32'h0, 32'h1);
    checks++;
    if (ovf_cnt !== 4'd2) begin
      errors++;
      $display("FAIL ovf_cnt_two: got %0d expected 2", ovf_cnt);
    end
  endtask

  task automatic test_branch_xor();
    run_op(6'h04, 6'h00, 32'h1234, 32'h1234);
    run_op(6'h04, 6'h00, 32'h1234, 32'h1235);
    checks++;
    if (br_cnt !== 4'd1) begin
      errors++;
      $display("FAIL br_cnt_one: got %0d expected 1", br_cnt);
    end
    run_op(6'h00, 6'h26, 32'hF0F0, 32'h0FF0);
  endtask

  task automatic test_illegal();
    run_op(6'h3F, 6'h20, 32'hAAAA_0001, 32'h5555_0002);
    run_op(6'h00, 6'h25, 32'h1111_1111, 32'h2222_2222);
  endtask

  task automatic test_backpressure();
    logic [35:0] held;
    out_ready = 1'b0;
    issue(6'h00, 6'h20, 32'h7, 32'h9);
    collect(3);
    held = {out_illegal, out_taken, out_ovf, out_zero, out_r};
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_opcode = 6'h00; in_funct = 6'h22;
      in_a = 32'h100 + 32'(i); in_b = 32'h1;
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 ||
          {out_illegal, out_taken, out_ovf, out_zero, out_r} !== held || alu_a !== last_a) begin
        errors++;
        $display("FAIL hold_%0d: got v=%b rdy=%b out=%h a=%h expected 1 0 %h %h",
                 i, out_valid, in_ready, {out_illegal, out_taken, out_ovf, out_zero, out_r},
                 alu_a, held, last_a);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    retire();
    run_op(6'h00, 6'h22, 32'h50, 32'h20);
  endtask

  task automatic test_random();
    int sel;
    logic [31:0] a, b;
    for (int i = 0; i < 24; i++) begin
      sel = $urandom_range(0, 5);
      a = $urandom;
      b = $urandom;
      case (sel)
        0: run_op(6'h00, 6'h20, a, b);
        1: run_op(6'h00, 6'h22, a, b);
        2: run_op(6'h00, 6'h26, a, b);
        3: run_op(6'h04, 6'($urandom_range(0, 63)), a, a);
        4: run_op(6'h04, 6'h00, a, b);
        default: run_op(6'($urandom_range(8, 63)), 6'h20, a, b);
      endcase
    end
  endtask

  task automatic test_reset_mid();
    in_opcode = 6'h00; in_funct = 6'h20; in_a = 32'hFFFF_FFFF; in_b = 32'h2; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (state_dbg !== 2'd2) begin
      errors++;
      $display("FAIL mid_state: got %0d expected 2", state_dbg);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    exp_ovf_cnt = '0; exp_br_cnt = '0;
    last_ctrl = 2'b00; last_a = '0; last_b = '0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || ovf_cnt !== '0) begin
        errors++;
        $display("FAIL mid_abandon_%0d: got out_valid=%b ovf_cnt=%0d expected 0 0",
                 i, out_valid, ovf_cnt);
      end
    end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 18; i++) run_op(6'h00, 6'h20, 32'hFFFF_FFFF, 32'(i + 1));
    for (int i = 0; i < 18; i++) run_op(6'h04, 6'h00, 32'(i * 3), 32'(i * 3));
    checks++;
    if (ovf_cnt !== 4'hF || br_cnt !== 4'hF) begin
      errors++;
      $display("FAIL saturate: got ovf=%0d br=%0d expected 15 15", ovf_cnt, br_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_overflow();
    test_branch_xor();
    test_illegal();
    test_backpressure();
    test_random();
    test_reset_mid();
    test_saturation();
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover: %0d results never observed", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
